// File: rtl/word_serializer.sv
// Wide-word queue feeding a character serializer with a valid/ready output handshake.
// Words are popped into a shift register and emitted DATA_SIZE bits at a time, LSB- or MSB-first.
module word_serializer #(
  parameter int DATA_SIZE   = 8,
  parameter int NUM_WORDS   = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                                  clk_100MHz,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  load,
  input  logic [DATA_SIZE*NUM_WORDS-1:0]        load_data,
  output logic                                  load_ready,
  output logic [DATA_SIZE-1:0]                  tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  empty,
  output logic                                  full,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      word_count
);

  localparam int WORD_W = DATA_SIZE * NUM_WORDS;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  logic [WORD_W-1:0]    mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_e               state_q, state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [IDX_W-1:0]     char_idx_q, char_idx_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 full_w, push, pop, mem_we;
  logic [WORD_W-1:0]    shifted;

  // The character presented first is always at one fixed end of the shift register.
  function automatic logic [DATA_SIZE-1:0] head_char(input logic [WORD_W-1:0] w);
    if (MSB_FIRST) return w[WORD_W-1 -: DATA_SIZE];
    else           return w[DATA_SIZE-1:0];
  endfunction

  assign full_w  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign shifted = MSB_FIRST ? (word_q << DATA_SIZE) : (word_q >> DATA_SIZE);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    word_d       = word_q;
    char_idx_d   = char_idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    push         = load && !full_w;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          word_d     = mem_q[rd_ptr_q];
          tx_data_d  = head_char(mem_q[rd_ptr_q]);
          tx_valid_d = 1'b1;
          char_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (char_idx_q == IDX_W'(NUM_WORDS - 1)) begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            char_idx_d = char_idx_q + IDX_W'(1);
            word_d     = shifted;
            tx_data_d  = head_char(shifted);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush discards the queue and the frame in progress; a same-cycle load is dropped.
    if (flush) begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = wr_ptr_q;
      count_d      = '0;
      state_d      = IDLE;
      tx_valid_d   = 1'b0;
      tx_data_d    = '0;
      frame_done_d = 1'b0;
    end
    mem_we = push && !flush && !reset;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      word_q       <= '0;
      char_idx_q   <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      word_q       <= word_d;
      char_idx_q   <= char_idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: queue storage has no reset; entries are only read once count says they were written.
  always_ff @(posedge clk_100MHz) begin
    if (mem_we) mem_q[wr_ptr_q] <= load_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign empty      = (count_q == '0);
  assign full       = full_w;
  assign load_ready = !full_w;
  assign word_count = count_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: an LSB-first and an MSB-first instance share stimulus,
// and each has a character scoreboard filled at load time and drained by a monitor.
module tb_word_serializer;

  logic        clk_100MHz = 1'b0;
  logic        reset, flush, load, tx_ready;
  logic [63:0] load_data;

  logic       load_ready_l, tx_valid_l, frame_done_l, busy_l, empty_l, full_l;
  logic [7:0] tx_data_l;
  logic [2:0] word_count_l;
  logic       load_ready_m, tx_valid_m, frame_done_m, busy_m, empty_m, full_m;
  logic [7:0] tx_data_m;
  logic [2:0] word_count_m;

  int checks = 0;
  int errors = 0;
  int fd_l   = 0;
  logic [7:0] sb_l[$];
  logic [7:0] sb_m[$];

  word_serializer #(.DATA_SIZE(8), .NUM_WORDS(8), .QUEUE_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_100MHz(clk_100MHz), .reset(reset), .flush(flush), .load(load), .load_data(load_data),
    .load_ready(load_ready_l), .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready),
    .frame_done(frame_done_l), .busy(busy_l), .empty(empty_l), .full(full_l),
    .word_count(word_count_l));

  word_serializer #(.DATA_SIZE(8), .NUM_WORDS(8), .QUEUE_DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk_100MHz(clk_100MHz), .reset(reset), .flush(flush), .load(load), .load_data(load_data),
    .load_ready(load_ready_m), .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready),
    .frame_done(frame_done_m), .busy(busy_m), .empty(empty_m), .full(full_m),
    .word_count(word_count_m));

  always #5 clk_100MHz = ~clk_100MHz;

  // Handshakes complete on the next rising edge, so negedge values describe that edge.
  always @(negedge clk_100MHz) begin
    logic [7:0] exp;
    if (frame_done_l === 1'b1) fd_l++;
    if (tx_valid_l === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (sb_l.size() == 0) begin
        errors++; $display("FAIL lsb_char unexpected got %h want none", tx_data_l);
      end else begin
        exp = sb_l.pop_front();
        if (tx_data_l !== exp) begin
          errors++; $display("FAIL lsb_char got %h want %h", tx_data_l, exp);
        end
      end
    end
    if (tx_valid_m === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (sb_m.size() == 0) begin
        errors++; $display("FAIL msb_char unexpected got %h want none", tx_data_m);
      end else begin
        exp = sb_m.pop_front();
        if (tx_data_m !== exp) begin
          errors++; $display("FAIL msb_char got %h want %h", tx_data_m, exp);
        end
      end
    end
  end

  function automatic logic [63:0] make_word(input int tag);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'((tag << 4) | j);
    return w;
  endfunction

  task automatic step();
    @(posedge clk_100MHz); #1;
  endtask

  task automatic push_exp(input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      sb_l.push_back(w[i*8 +: 8]);
      sb_m.push_back(w[(7-i)*8 +: 8]);
    end
  endtask

  // Called in the post-posedge slot; holds load for exactly one edge.
  task automatic load_word(input logic [63:0] w, input bit expect_accept);
    load = 1'b1; load_data = w;
    if (expect_accept) push_exp(w);
    step();
    load = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb_l.size() != 0 || sb_m.size() != 0 || busy_l || !empty_l) && n < 400) begin
      @(negedge clk_100MHz); n++;
    end
    checks++;
    if (n >= 400) begin
      errors++; $display("FAIL %s_drain timeout left %0d want 0", name, sb_l.size());
    end
    @(negedge clk_100MHz);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; load = 1'b0; tx_ready = 1'b0; load_data = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk_100MHz);
    checks += 8;
    if (tx_valid_l !== 1'b0)   begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid_l); end
    if (tx_data_l !== 8'h00)   begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data_l); end
    if (frame_done_l !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done_l); end
    if (busy_l !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy_l); end
    if (empty_l !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b want 1", empty_l); end
    if (full_l !== 1'b0)       begin errors++; $display("FAIL reset_full got %b want 0", full_l); end
    if (load_ready_l !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready_l); end
    if (word_count_l !== 3'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count_l); end
  endtask

  task automatic test_basic();
    int fd0;
    step();
    tx_ready = 1'b1; fd0 = fd_l;
    load_word(64'h0706050403020100, 1'b1);
    @(negedge clk_100MHz);
    checks++;
    if (tx_valid_l !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %b want 0", tx_valid_l); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_100MHz);
      checks++;
      if (tx_valid_l !== 1'b1 || tx_valid_m !== 1'b1) begin
        errors++; $display("FAIL basic_stream cycle %0d got %b/%b want 1/1", i, tx_valid_l, tx_valid_m);
      end
    end
    wait_drain("basic");
    checks += 3;
    if (fd_l - fd0 !== 1) begin errors++; $display("FAIL basic_frame_done got %0d want 1", fd_l - fd0); end
    if (busy_l !== 1'b0)  begin errors++; $display("FAIL basic_busy got %b want 0", busy_l); end
    if (empty_l !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", empty_l); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    step();
    tx_ready = 1'b1;
    load_word(64'h1716151413121110, 1'b1);
    while (!(tx_valid_l === 1'b1 && tx_data_l === 8'h12) && n < 20) begin
      @(negedge clk_100MHz); n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL bp_reach timeout got %h want 12", tx_data_l); end
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100MHz);
      checks++;
      if (tx_valid_l !== 1'b1 || tx_data_l !== 8'h13 || tx_data_m !== 8'h14) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got %b %h %h want 1 13 14", i, tx_valid_l, tx_data_l, tx_data_m);
      end
    end
    step();
    tx_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_fill();
    int fd0, nhs, gaps, n;
    step();
    tx_ready = 1'b0; fd0 = fd_l;
    for (int i = 0; i < 6; i++) load_word(make_word(4 + i), i < 5);
    @(negedge clk_100MHz);
    checks += 4;
    if (full_l !== 1'b1)       begin errors++; $display("FAIL fill_full got %b want 1", full_l); end
    if (load_ready_l !== 1'b0) begin errors++; $display("FAIL fill_load_ready got %b want 0", load_ready_l); end
    if (word_count_l !== 3'd4) begin errors++; $display("FAIL fill_word_count got %0d want 4", word_count_l); end
    if (busy_l !== 1'b1)       begin errors++; $display("FAIL fill_busy got %b want 1", busy_l); end
    step();
    tx_ready = 1'b1;
    nhs = 0; gaps = 0; n = 0;
    while (nhs < 40 && n < 200) begin
      @(negedge clk_100MHz); n++;
      if (tx_valid_l) nhs++;
      else gaps++;
    end
    checks += 2;
    if (nhs !== 40) begin errors++; $display("FAIL fill_chars got %0d want 40", nhs); end
    if (gaps !== 4) begin errors++; $display("FAIL fill_bubbles got %0d want 4", gaps); end
    wait_drain("fill");
    checks++;
    if (fd_l - fd0 !== 5) begin errors++; $display("FAIL fill_frame_done got %0d want 5", fd_l - fd0); end
  endtask

  task automatic test_simul();
    int n = 0;
    step();
    tx_ready = 1'b0;
    load_word(make_word(10), 1'b1);
    load_word(make_word(11), 1'b1);
    load_word(make_word(12), 1'b1);
    @(negedge clk_100MHz);
    checks++;
    if (word_count_l !== 3'd2) begin errors++; $display("FAIL simul_pre_count got %0d want 2", word_count_l); end
    step();
    tx_ready = 1'b1;
    while (frame_done_l !== 1'b1 && n < 40) begin
      @(negedge clk_100MHz); n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL simul_frame timeout got %b want 1", frame_done_l); end
    // Serializer is IDLE with two words queued: the coming edge both pops and accepts.
    load = 1'b1; load_data = make_word(13); push_exp(make_word(13));
    @(posedge clk_100MHz); #1;
    load = 1'b0;
    @(negedge clk_100MHz);
    checks += 2;
    if (word_count_l !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", word_count_l); end
    if (tx_valid_l !== 1'b1)   begin errors++; $display("FAIL simul_valid got %b want 1", tx_valid_l); end
    wait_drain("simul");
  endtask

  task automatic test_recover(input bit use_reset, input string name);
    int n = 0;
    logic [63:0] x;
    x = make_word(1);
    step();
    tx_ready = 1'b0;
    load_word(x, 1'b1);
    load_word(make_word(2), 1'b1);
    load_word(make_word(3), 1'b1);
    step();
    tx_ready = 1'b1;
    while (!(tx_valid_l === 1'b1 && tx_data_l === x[31:24]) && n < 40) begin
      @(negedge clk_100MHz); n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL %s_reach timeout got %h want %h", name, tx_data_l, x[31:24]); end
    step();
    tx_ready = 1'b0;
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    load = 1'b1; load_data = make_word(14);
    sb_l.delete(); sb_m.delete();
    step();
    reset = 1'b0; flush = 1'b0; load = 1'b0;
    @(negedge clk_100MHz);
    checks += 5;
    if (tx_valid_l !== 1'b0 || tx_valid_m !== 1'b0) begin
      errors++; $display("FAIL %s_tx_valid got %b/%b want 0/0", name, tx_valid_l, tx_valid_m);
    end
    if (busy_l !== 1'b0)       begin errors++; $display("FAIL %s_busy got %b want 0", name, busy_l); end
    if (empty_l !== 1'b1)      begin errors++; $display("FAIL %s_empty got %b want 1", name, empty_l); end
    if (word_count_l !== 3'd0) begin errors++; $display("FAIL %s_word_count got %0d want 0", name, word_count_l); end
    if (frame_done_l !== 1'b0) begin errors++; $display("FAIL %s_frame_done got %b want 0", name, frame_done_l); end
    if (use_reset) begin
      checks += 2;
      if (tx_data_l !== 8'h00)   begin errors++; $display("FAIL %s_tx_data got %h want 00", name, tx_data_l); end
      if (load_ready_l !== 1'b1) begin errors++; $display("FAIL %s_load_ready got %b want 1", name, load_ready_l); end
    end
    step();
    tx_ready = 1'b1;
    load_word(make_word(15), 1'b1);
    wait_drain(name);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fill();
    test_simul();
    test_recover(1'b0, "flush");
    test_recover(1'b1, "rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
